conv_window_gen: RTL and testbench

- Streaming window generator directly upstream of the 5x5 convolution point.
- Accepts a raster-order feature map one signed pixel per handshake.
- Buffers K-1 lines and presents every valid-mode (no padding) KxK window as a registered 2-D array, indexed exactly like the convolver's map_block input.
- Throughput is one window per clock under no backpressure.

---
 rtl/conv_pkg.sv | 13 +
 rtl/conv_line_buffer.sv | 33 +++
 rtl/conv_window_gen.sv | 143 ++++++++++++++
 tb/tb_conv_window_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the 5x5 convolution datapath: pixel and window shapes.
package conv_pkg;

    localparam int unsigned BITWIDTH = 16;
    localparam int unsigned K = 5;

    typedef logic signed [BITWIDTH-1:0] pixel_t;
    typedef pixel_t window_t [K-1:0][K-1:0];
    typedef pixel_t column_t [K-2:0];

    typedef enum logic [0:0] {StFill, StRun} win_state_e;

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 stacked line buffers; each column read returns the K-1 previous rows at that column.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned AW = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          shift_en,
    input  logic [AW-1:0] addr,
    input  pixel_t        din,
    output column_t       col
);

    pixel_t mem_q [K-1][IMG_W];

    // Read is combinational so the old column is seen before the shift lands.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col[i] = mem_q[i][addr];
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = 0; i < K - 2; i++) begin
                mem_q[i][addr] <= mem_q[i+1][addr];
            end
            mem_q[K-2][addr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streams a raster feature map and emits every valid-mode KxK window, one per accepted pixel.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned CW = $clog2(IMG_W),
    parameter int unsigned RW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  pixel_t        in_pixel,
    output logic          out_valid,
    input  logic          out_ready,
    output window_t       out_window,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          out_last
);

    localparam logic [CW-1:0] ColMax = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowMax = RW'(IMG_H - 1);
    localparam logic [CW-1:0] ColEdge = CW'(K - 1);
    localparam logic [RW-1:0] RowEdge = RW'(K - 1);
    localparam logic [RW-1:0] RowFillEnd = RW'(K - 2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    win_state_e    state_q, state_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;
    window_t       win_q, win_d;

    logic    acc, consume, complete, col_last, row_last;
    column_t lb_col;
    pixel_t  vec [K-1:0];

    assign in_ready = !out_valid_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;
    assign col_last = (col_q == ColMax);
    assign row_last = (row_q == RowMax);
    // In StRun the row bound already holds; only the column test remains.
    assign complete = (state_q == StRun) && (col_q >= ColEdge);

    conv_line_buffer #(
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk      (clk),
        .shift_en (acc),
        .addr     (col_q),
        .din      (in_pixel),
        .col      (lb_col)
    );

    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            vec[i] = lb_col[i];
        end
        vec[K-1] = in_pixel;
    end

    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K - 1; j++) begin
                    win_d[i][j] = win_q[i][j+1];
                end
                win_d[i][K-1] = vec[i];
            end
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;

        if (acc) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end

            unique case (state_q)
                StFill:  if (col_last && row_q == RowFillEnd) state_d = StRun;
                StRun:   if (col_last && row_last) state_d = StFill;
                default: state_d = StFill;
            endcase

            out_valid_d = complete;
            out_last_d  = complete && col_last && row_last;
            if (complete) begin
                out_row_d = row_q - RowEdge;
                out_col_d = col_q - ColEdge;
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            state_q     <= StFill;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_window = win_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen on an 8x8 frame with a frame-image reference model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 8;

    typedef struct packed {
        logic [K*K*BITWIDTH-1:0] win;
        logic [2:0]              row;
        logic [2:0]              col;
        logic                    last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready, out_last;
    pixel_t     in_pixel;
    window_t    out_window;
    logic [2:0] out_row, out_col;

    int   checks = 0;
    int   errors = 0;
    int   win_cnt = 0;
    int   ready_mode = 0;
    bit   bp_done = 0;
    bit   exp_valid = 0;
    bit   have_prev = 0;
    exp_t q[$];
    pixel_t  img [H][W];
    int      mr = 0;
    int      mc = 0;
    window_t prev_win;
    logic [2:0] prev_row, prev_col;
    logic       prev_last;

    always #5 clk = ~clk;

    conv_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_last   (out_last)
    );

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: store the frame image, emit a window whenever its bottom-right lands.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mr = 0;
            mc = 0;
            exp_valid = 0;
            have_prev = 0;
        end else begin
            check("out_valid", longint'(out_valid), longint'(exp_valid));
            check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
            if (have_prev) begin
                int diff;
                diff = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        if (out_window[i][j] !== prev_win[i][j]) diff++;
                check("stall_window_stable", diff, 0);
                check("stall_meta_stable", {out_row, out_col, out_last},
                      {prev_row, prev_col, prev_last});
            end
            have_prev = out_valid && !out_ready;
            prev_win  = out_window;
            prev_row  = out_row;
            prev_col  = out_col;
            prev_last = out_last;

            if (out_valid && out_ready) begin
                win_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_window", 1, 0);
                end else begin
                    exp_t e;
                    int   bad, bi, bj;
                    e = q.pop_front();
                    bad = 0;
                    bi = 0;
                    bj = 0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            if (out_window[i][j] !== pixel_t'(e.win[(i*K+j)*BITWIDTH +: BITWIDTH]))
                            begin
                                if (bad == 0) begin bi = i; bj = j; end
                                bad++;
                            end
                    checks++;
                    if (bad != 0) begin
                        errors++;
                        $display("FAIL window[%0d][%0d] top(%0d,%0d): got %0d, expected %0d (%0d bad)",
                                 bi, bj, e.row, e.col, out_window[bi][bj],
                                 pixel_t'(e.win[(bi*K+bj)*BITWIDTH +: BITWIDTH]), bad);
                    end
                    check("out_row", longint'(out_row), longint'(e.row));
                    check("out_col", longint'(out_col), longint'(e.col));
                    check("out_last", longint'(out_last), longint'(e.last));
                end
                exp_valid = 0;
            end

            if (in_valid && in_ready) begin
                img[mr][mc] = in_pixel;
                exp_valid = 0;
                if (mr >= K - 1 && mc >= K - 1) begin
                    exp_t e;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            e.win[(i*K+j)*BITWIDTH +: BITWIDTH] = img[mr-K+1+i][mc-K+1+j];
                    e.row  = 3'(mr - K + 1);
                    e.col  = 3'(mc - K + 1);
                    e.last = (mr == H - 1) && (mc == W - 1);
                    q.push_back(e);
                    exp_valid = 1;
                end
                if (mc == W - 1) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
    end

    // Consumer side: always ready, random ready, or a 5-cycle stall on the first window.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: out_ready = 1'($urandom_range(1, 0));
                2: begin
                    if (!bp_done && out_valid) begin
                        out_ready = 1'b0;
                        repeat (5) @(posedge clk);
                        #1;
                        out_ready = 1'b1;
                        bp_done = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send_px(input pixel_t v, input bit rnd_valid);
        int guard;
        if (rnd_valid) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_pixel = v;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic pixel_t rand_px();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            default: return pixel_t'(r[15:0]);
        endcase
    endfunction

    task automatic send_frame(input int base, input bit rnd);
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++)
                send_px(rnd ? rand_px() : pixel_t'(base + r * 16 + c), rnd);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0 || out_valid) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", longint'(out_valid), 0);
        check("reset_out_last", longint'(out_last), 0);
        check("reset_out_row", longint'(out_row), 0);
        check("reset_out_col", longint'(out_col), 0);
        check("reset_in_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single frame, continuous traffic.
        win_cnt = 0;
        send_frame(0, 0);
        drain();
        check("frame1_windows", win_cnt, 16);

        // Stall the first window for five cycles.
        ready_mode = 2;
        bp_done = 0;
        win_cnt = 0;
        send_frame(0, 0);
        drain();
        check("backpressure_windows", win_cnt, 16);
        ready_mode = 0;

        // Two frames back to back.
        win_cnt = 0;
        send_frame(0, 0);
        send_frame(32'h100, 0);
        drain();
        check("two_frame_windows", win_cnt, 32);

        // Reset in the middle of a frame.
        for (int n = 0; n < 20; n++) send_px(pixel_t'(16'h0200 + n), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        win_cnt = 0;
        send_frame(32'h300, 0);
        drain();
        check("post_reset_windows", win_cnt, 16);

        // Random handshakes and signed extremes over three frames.
        ready_mode = 1;
        win_cnt = 0;
        for (int f = 0; f < 3; f++) send_frame(0, 1);
        drain();
        check("random_windows", win_cnt, 48);
        ready_mode = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
